// File: rtl/core_mem_pkg.sv
// Shared encodings for the core memory server: per-core status codes and the
// state enums of the top-level run FSM and the per-core transaction slots.
package core_mem_pkg;

  localparam logic [1:0] ST_HOLD = 2'b00;
  localparam logic [1:0] ST_GO   = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    TOP_IDLE = 2'd0,
    TOP_RUN  = 2'd1,
    TOP_DONE = 2'd2
  } top_state_t;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_WAIT = 2'd1,
    SLOT_ACK  = 2'd2
  } slot_state_t;

  // Run-cycle counter sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// rotating pointer; the pointer moves to the slot after the winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         grant_valid
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0] N_W = (PW + 1)'(N);
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] win;
  logic [PW-1:0] probe;
  logic [PW:0]   sum;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    win         = '0;
    probe       = '0;
    sum         = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr_reg} + (PW + 1)'(off);
      if (sum >= N_W) begin
        sum = sum - N_W;
      end
      probe = sum[PW-1:0];
      if (!grant_valid && req[probe]) begin
        grant_valid = 1'b1;
        win         = probe;
      end
    end
    grant[win] = grant_valid;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (grant_valid) begin
      ptr_reg <= (win == LAST) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/core_mem_server.sv
// Memory-side responder: round-robin arbitration of NUM_CORES cores onto one
// synchronous RAM port, per-core status handshaking and run/done bookkeeping.
module core_mem_server
  import core_mem_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int AW        = 16,
  parameter int DW        = 16
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [NUM_CORES*AW-1:0] core_addr,
  input  logic [NUM_CORES*DW-1:0] core_wdata,
  input  logic [NUM_CORES-1:0]    core_wr,
  input  logic [NUM_CORES-1:0]    core_rd,
  input  logic [NUM_CORES-1:0]    core_end,
  output logic [NUM_CORES*DW-1:0] core_rdata,
  output logic [NUM_CORES*2-1:0]  core_status,
  output logic [AW-1:0]           mem_addr,
  output logic [DW-1:0]           mem_wdata,
  output logic                    mem_we,
  input  logic [DW-1:0]           mem_rdata,
  output logic                    all_done,
  output logic [31:0]             cycle_count
);

  top_state_t state_reg;

  logic [NUM_CORES-1:0] pend_vec;
  logic [NUM_CORES-1:0] done_mask;
  logic [NUM_CORES-1:0] busy_vec;
  logic [NUM_CORES-1:0] arb_req;
  logic [NUM_CORES-1:0] grant;
  logic                 grant_valid;
  logic                 run;
  logic                 begin_run;
  logic                 finish;
  logic [AW-1:0]        sel_addr;
  logic [DW-1:0]        sel_wdata;
  logic                 sel_we;

  assign run       = (state_reg == TOP_RUN);
  assign begin_run = start && !run;
  assign finish    = run && (&done_mask) && !(|busy_vec);
  assign arb_req   = run ? (pend_vec & ~done_mask) : '0;

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clock       (clock),
    .rst_n       (rst_n),
    .req         (arb_req),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant[i]) begin
        sel_addr  = core_addr[i*AW +: AW];
        sel_wdata = core_wdata[i*DW +: DW];
        sel_we    = core_wr[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_reg   <= TOP_IDLE;
      all_done    <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state_reg)
        TOP_IDLE: begin
          if (start) begin
            state_reg   <= TOP_RUN;
            cycle_count <= '0;
          end
        end
        TOP_RUN: begin
          cycle_count <= sat_inc32(cycle_count);
          if (finish) begin
            state_reg <= TOP_DONE;
            all_done  <= 1'b1;
          end
        end
        TOP_DONE: begin
          if (start) begin
            state_reg   <= TOP_RUN;
            all_done    <= 1'b0;
            cycle_count <= '0;
          end
        end
        default: state_reg <= TOP_IDLE;
      endcase
    end
  end

  // mem_we is a one-cycle strobe; address and data hold their last grant.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else if (grant_valid) begin
      mem_addr  <= sel_addr;
      mem_wdata <= sel_wdata;
      mem_we    <= sel_we;
    end else begin
      mem_we <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_slot
    slot_state_t   slot_reg;
    logic          second_reg;
    logic          is_read_reg;
    logic          pend_reg;
    logic          done_reg;
    logic [1:0]    status_reg;
    logic [DW-1:0] rdata_reg;
    logic          done_now;
    logic          want;

    assign done_now  = done_reg | core_end[gi];
    assign want      = core_rd[gi] | core_wr[gi];
    assign pend_vec[gi]  = pend_reg;
    assign done_mask[gi] = done_reg;
    assign busy_vec[gi]  = (slot_reg != SLOT_IDLE);
    assign core_status[gi*2 +: 2]  = status_reg;
    assign core_rdata[gi*DW +: DW] = rdata_reg;

    // Status is registered from the slot's next state so it lines up with it.
    always_ff @(posedge clock) begin
      if (!rst_n) begin
        slot_reg    <= SLOT_IDLE;
        second_reg  <= 1'b0;
        is_read_reg <= 1'b0;
        pend_reg    <= 1'b0;
        done_reg    <= 1'b0;
        status_reg  <= ST_HOLD;
        rdata_reg   <= '0;
      end else if (begin_run) begin
        pend_reg   <= 1'b0;
        done_reg   <= 1'b0;
        status_reg <= ST_GO;
      end else if (finish) begin
        status_reg <= ST_DONE;
      end else if (run) begin
        if (core_end[gi]) begin
          done_reg <= 1'b1;
        end
        case (slot_reg)
          SLOT_IDLE: begin
            if (grant[gi]) begin
              slot_reg    <= SLOT_WAIT;
              second_reg  <= 1'b0;
              pend_reg    <= 1'b0;
              is_read_reg <= !core_wr[gi];
              status_reg  <= done_now ? ST_DONE : ST_HOLD;
            end else if (done_reg) begin
              pend_reg   <= 1'b0;
              status_reg <= ST_DONE;
            end else if (pend_reg || want) begin
              pend_reg   <= 1'b1;
              status_reg <= done_now ? ST_DONE : ST_HOLD;
            end else begin
              status_reg <= done_now ? ST_DONE : ST_GO;
            end
          end
          SLOT_WAIT: begin
            if (second_reg) begin
              slot_reg   <= SLOT_ACK;
              status_reg <= done_now ? ST_DONE : ST_GO;
              if (is_read_reg) begin
                rdata_reg <= mem_rdata;
              end
            end else begin
              second_reg <= 1'b1;
              status_reg <= done_now ? ST_DONE : ST_HOLD;
            end
          end
          SLOT_ACK: begin
            slot_reg   <= SLOT_IDLE;
            status_reg <= done_now ? ST_DONE : ST_GO;
          end
          default: slot_reg <= SLOT_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_core_mem_server.sv
// Bench for core_mem_server: directed vector table, arbitration bursts, end and
// reset corner cases, then random traffic against a per-core memory scoreboard.
module tb_core_mem_server;
  import core_mem_pkg::*;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] core_addr;
  logic [63:0] core_wdata;
  logic [3:0]  core_wr;
  logic [3:0]  core_rd;
  logic [3:0]  core_end;
  logic [63:0] core_rdata;
  logic [7:0]  core_status;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        all_done;
  logic [31:0] cycle_count;

  logic [15:0] ram [65536];

  int pass_count = 0;
  int total_count = 0;

  always #5 clock = ~clock;

  core_mem_server #(.NUM_CORES(4), .AW(16), .DW(16)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .start       (start),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_wr     (core_wr),
    .core_rd     (core_rd),
    .core_end    (core_end),
    .core_rdata  (core_rdata),
    .core_status (core_status),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata),
    .all_done    (all_done),
    .cycle_count (cycle_count)
  );

  // Synchronous RAM: write and registered read on the same edge.
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    int          core;
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        exp_we;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_count++;
    if (act === exp) pass_count++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [1:0] status_of(input int c);
    return core_status[c*2 +: 2];
  endfunction

  function automatic logic [15:0] rdata_of(input int c);
    return core_rdata[c*16 +: 16];
  endfunction

  task automatic set_core(input int c, input logic wr, input logic rd,
                          input logic [15:0] a, input logic [15:0] d);
    core_addr[c*16 +: 16]  = a;
    core_wdata[c*16 +: 16] = d;
    core_wr[c] = wr;
    core_rd[c] = rd;
  endtask

  // All four cores read at once; order[] is the expected grant sequence.
  task automatic run_burst(input int order [4], input string tag);
    for (int c = 0; c < 4; c++) set_core(c, 1'b0, 1'b1, 16'h0100 + 16'(c), 16'h0000);
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 1) check({tag, "_hold"}, core_status, 8'h00);
      if (e >= 2 && e <= 5) check({tag, "_addr"}, mem_addr, 16'h0100 + 16'(order[e-2]));
      if (e >= 4) begin
        check({tag, "_go"}, status_of(order[e-4]), ST_GO);
        core_rd[order[e-4]] = 1'b0;
      end
    end
    $display("txn burst %s order %0d %0d %0d %0d", tag, order[0], order[1], order[2], order[3]);
    tick();
    tick();
  endtask

  // Scoreboard state for the random phase.
  logic [15:0] shadow [32];
  logic [15:0] exp_rd [4];
  logic        busy [4];
  logic        seen_hold [4];
  logic        op_wr [4];
  int          op_idx [4];
  logic [15:0] op_data [4];
  int          lat [4];

  initial begin
    int c;
    int done_ops;
    logic [31:0] frozen;
    int order1 [4];
    int order2 [4];

    for (int a = 0; a < 65536; a++) ram[a] = 16'h0000;
    rst_n = 1'b0; start = 1'b0;
    core_addr = '0; core_wdata = '0; core_wr = '0; core_rd = '0; core_end = '0;

    vecs[0] = '{0, 1'b1, 1'b0, 16'h0010, 16'hABCD, 1'b1, 16'h0000};
    vecs[1] = '{0, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, 16'hABCD};
    vecs[2] = '{1, 1'b0, 1'b1, 16'h0010, 16'h0F0F, 1'b0, 16'hABCD};
    vecs[3] = '{1, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b1, 16'hABCD};
    vecs[4] = '{1, 1'b0, 1'b1, 16'h0020, 16'h7777, 1'b0, 16'h1234};
    vecs[5] = '{2, 1'b1, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0000};
    vecs[6] = '{3, 1'b0, 1'b1, 16'hFFFF, 16'h5555, 1'b0, 16'h0001};

    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_status", core_status, 8'h00);
    check("rst_rdata", core_rdata, 64'h0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_all_done", all_done, 1'b0);
    check("rst_cycle_count", cycle_count, 32'd0);

    start = 1'b1; tick(); start = 1'b0;
    check("start_status", core_status, 8'h55);
    check("start_count", cycle_count, 32'd0);
    repeat (5) tick();
    check("count_5", cycle_count, 32'd5);
    start = 1'b1; tick(); start = 1'b0;
    check("start_in_run_ignored", cycle_count, 32'd6);

    for (int v = 0; v < 7; v++) begin
      c = vecs[v].core;
      set_core(c, vecs[v].wr, vecs[v].rd, vecs[v].addr, vecs[v].wdata);
      tick();
      check($sformatf("v%0d_hold_e1", v), status_of(c), ST_HOLD);
      tick();
      check($sformatf("v%0d_we", v), mem_we, vecs[v].exp_we);
      check($sformatf("v%0d_addr", v), mem_addr, vecs[v].addr);
      check($sformatf("v%0d_wdata", v), mem_wdata, vecs[v].wdata);
      check($sformatf("v%0d_hold_e2", v), status_of(c), ST_HOLD);
      tick();
      check($sformatf("v%0d_hold_e3", v), status_of(c), ST_HOLD);
      tick();
      check($sformatf("v%0d_go", v), status_of(c), ST_GO);
      check($sformatf("v%0d_rdata", v), rdata_of(c), vecs[v].exp_rdata);
      $display("txn vec %0d core=%0d wr=%0b rd=%0b addr=%h rdata=%h",
               v, c, vecs[v].wr, vecs[v].rd, vecs[v].addr, rdata_of(c));
      set_core(c, 1'b0, 1'b0, 16'h0000, 16'h0000);
      tick(); tick();
    end

    order1 = '{0, 1, 2, 3};
    run_burst(order1, "burst1");
    set_core(1, 1'b0, 1'b1, 16'h0101, 16'h0000);
    repeat (4) tick();
    check("single_core1_go", status_of(1), ST_GO);
    core_rd[1] = 1'b0;
    tick(); tick();
    order2 = '{2, 3, 0, 1};
    run_burst(order2, "burst2");

    // core_end on every core while core2's read is in flight.
    set_core(2, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
    tick();
    tick();
    check("end_grant_addr", mem_addr, 16'hFFFF);
    core_end = 4'hF;
    tick();
    check("end_status_done", core_status, 8'hAA);
    tick();
    check("end_read_completes", rdata_of(2), 16'h0001);
    check("end_not_done_e4", all_done, 1'b0);
    tick();
    check("end_not_done_e5", all_done, 1'b0);
    tick();
    check("end_all_done", all_done, 1'b1);
    frozen = cycle_count;
    core_end = 4'h0; core_rd = 4'h0;
    repeat (3) tick();
    check("end_count_frozen", cycle_count, frozen);
    check("end_status_hold_done", core_status, 8'hAA);
    $display("txn end run cycles=%0d", frozen);

    start = 1'b1; tick(); start = 1'b0;
    check("restart_done_low", all_done, 1'b0);
    check("restart_count", cycle_count, 32'd0);
    check("restart_status", core_status, 8'h55);

    // Reset lands on the edge that would grant core0's write.
    set_core(0, 1'b1, 1'b0, 16'h0030, 16'hBEEF);
    tick();
    rst_n = 1'b0;
    tick();
    check("rst2_mem_we", mem_we, 1'b0);
    check("rst2_mem_addr", mem_addr, 16'h0000);
    check("rst2_mem_wdata", mem_wdata, 16'h0000);
    check("rst2_status", core_status, 8'h00);
    check("rst2_rdata", core_rdata, 64'h0);
    check("rst2_all_done", all_done, 1'b0);
    check("rst2_count", cycle_count, 32'd0);
    tick();
    check("rst2_no_write", ram[16'h0030], 16'h0000);
    check("rst2_mem_we_held", mem_we, 1'b0);
    set_core(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rst_n = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;

    // Random traffic: each core uses its own 8-word region of memory.
    for (int i = 0; i < 32; i++) shadow[i] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      exp_rd[i] = 16'h0000; busy[i] = 1'b0; seen_hold[i] = 1'b0; lat[i] = 0;
    end
    done_ops = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        if (busy[k]) begin
          lat[k]++;
          if (status_of(k) == ST_HOLD) begin
            seen_hold[k] = 1'b1;
          end else if (seen_hold[k] && status_of(k) == ST_GO) begin
            if (op_wr[k]) shadow[op_idx[k]] = op_data[k];
            else exp_rd[k] = shadow[op_idx[k]];
            check($sformatf("rand_rdata_c%0d", k), rdata_of(k), exp_rd[k]);
            check($sformatf("rand_latency_c%0d", k), (lat[k] >= 3 && lat[k] <= 8), 1'b1);
            $display("txn rand core=%0d wr=%0b idx=%0d lat=%0d rdata=%h",
                     k, op_wr[k], op_idx[k], lat[k], rdata_of(k));
            set_core(k, 1'b0, 1'b0, 16'h0000, 16'h0000);
            busy[k] = 1'b0;
            done_ops++;
          end else if (lat[k] > 20) begin
            check($sformatf("rand_timeout_c%0d", k), lat[k], 8);
            set_core(k, 1'b0, 1'b0, 16'h0000, 16'h0000);
            busy[k] = 1'b0;
          end
        end else if (cyc < 500 && $urandom_range(0, 1) == 1) begin
          int kind;
          int off;
          kind = $urandom_range(0, 2);
          off  = $urandom_range(0, 7);
          op_wr[k]   = (kind != 0);
          op_idx[k]  = k * 8 + off;
          op_data[k] = 16'($urandom);
          set_core(k, (kind != 0), (kind != 1),
                   16'(k << 12) | 16'h0800 | 16'(off), op_data[k]);
          busy[k] = 1'b1; seen_hold[k] = 1'b0; lat[k] = 0;
        end
      end
    end
    check("rand_drained", {busy[0], busy[1], busy[2], busy[3]}, 4'h0);
    check("rand_enough_ops", (done_ops > 100), 1'b1);

    core_end = 4'hF;
    for (int w = 0; w < 10 && !all_done; w++) tick();
    check("rand_end_all_done", all_done, 1'b1);
    check("rand_end_status", core_status, 8'hAA);
    frozen = cycle_count;
    tick(); tick();
    check("rand_end_frozen", cycle_count, frozen);
    core_end = 4'h0;

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/core_mem_server.md
Name: core_mem_server

Overview:
- Memory-side responder for the shared data memory in the multicore matrix-multiply system.
- Serves NUM_CORES processor cores. Each core presents an address, write data, and read/write requests.
- Arbitrates the cores round-robin onto one synchronous-RAM port and returns read data to the requesting core.
- Drives each core's 2-bit status (HOLD/GO/DONE), collects the cores' end-of-process flags, and raises all_done.

Parameters:
- NUM_CORES, 4, number of cores served.
- AW, 16, address width.
- DW, 16, data width.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset: one clock; reset is synchronous and active-low.
- start  in  1  pulse; begins a run from IDLE or DONE.
- core_addr  in  NUM_CORES*AW  per-core address; core i occupies bits [i*AW +: AW].
- core_wdata  in  NUM_CORES*DW  per-core write data.
- core_wr  in  NUM_CORES  per-core write request (level).
- core_rd  in  NUM_CORES  per-core read request (level).
- core_end  in  NUM_CORES  per-core end_process flag.
- core_rdata  out  NUM_CORES*DW  per-core registered read data.
- core_status  out  NUM_CORES*2  per-core status: 00 HOLD, 01 GO, 10 DONE.
- mem_addr  out  AW  RAM address (registered).
- mem_wdata  out  DW  RAM write data (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_rdata  in  DW  RAM read data; valid one cycle after mem_addr is presented.
- all_done  out  1  high while in DONE.
- cycle_count  out  32  number of RUN cycles in the current or last run.

Behaviour:
- Reset (rst_n=0 at a rising edge) forces:
  - state=IDLE, all core_status=HOLD, core_rdata=0, mem_addr=0, mem_wdata=0, mem_we=0, all_done=0, cycle_count=0.
  - RR pointer=0, done_mask=0, all per-core slots IDLE.
  - Any in-flight transaction is dropped; no write is issued after reset.
- Top FSM:
  - IDLE: all status HOLD. start -> RUN, clearing done_mask and cycle_count.
  - RUN: cycle_count increments every cycle. Exits to DONE when done_mask is all-ones and no slot is WAIT or ACK.
  - DONE: all_done=1, all status DONE. start -> RUN, clearing done_mask and cycle_count.
- Per-core slot FSM (RUN only):
  - IDLE -> WAIT when the core is granted.
  - WAIT lasts exactly 2 cycles -> ACK.
  - ACK lasts 1 cycle -> IDLE.
- Request and ack rules:
  - A request is core_rd|core_wr sampled while the slot is IDLE and done_mask[i]=0.
  - Request bits are not sampled during the ACK cycle.
  - A core must hold its address, data and request stable while its status is HOLD.
- Status per core in RUN:
  - DONE if done_mask[i]=1.
  - HOLD if a request is pending ungranted, or the slot is WAIT.
  - GO if the slot is ACK, or there is no request.
- Arbitration:
  - One grant per cycle among eligible requesters.
  - Search starts at the RR pointer. After a grant, the pointer becomes g+1 mod NUM_CORES.
- Timing for a grant to core g at edge k:
  - Edge k: mem_addr, mem_wdata and mem_we are registered from core g. mem_we=core_wr[g], and mem_we=0 on cycles with no grant.
  - Edge k+1: the RAM performs the write, or produces read data.
  - Edge k+2: core_rdata[g] <= mem_rdata for reads only; write acks leave core_rdata unchanged. Slot enters ACK, so status[g]=GO for one cycle.
  - Read latency from request sampled to GO is 3 edges.
  - Pipelined throughput is one transaction per cycle across distinct cores.
- Conflicts and edge cases:
  - core_wr and core_rd both high: treated as a write; the read is ignored.
  - core_end[i]=1 in RUN sets done_mask[i]. A transaction already granted to that core completes normally; no new grants are made to it.
  - start while in RUN is ignored.
  - cycle_count saturates at 2^32-1.

Decomposition:
- Shared package core_mem_pkg holds:
  - Status encodings ST_HOLD=2'b00, ST_GO=2'b01, ST_DONE=2'b10.
  - Top FSM state enum IDLE/RUN/DONE.
  - Slot state enum IDLE/WAIT/ACK.
- One sub-module rr_arbiter (parameter N): inputs req[N], clock, rst_n; outputs one-hot grant[N] and grant_valid. It holds the rotating pointer.

Test Plan:
- Reset then start; core0 issues a write of addr 0x0010, data 0xABCD -> mem_we=1 with mem_addr=0x0010 one edge after sampling; status0 GO exactly 3 edges after the request; status0 HOLD in between.
- Core0 reads 0x0010 after the write -> core_rdata[0]=0xABCD at the GO cycle.
- All 4 cores request in the same cycle, pointer=0 -> grants in order 0,1,2,3 on consecutive edges; GO pulses on consecutive cycles; the next simultaneous burst starts at the pointer's new position.
- Core1 asserts wr and rd together, data 0x1234 -> write performed, core_rdata[1] unchanged.
- core_end asserted on cores 0-3 while core2's read is in flight -> the read completes, then all_done=1, all status DONE, and cycle_count frozen.
- rst_n=0 in the cycle after a write grant -> mem_we=0 from the next edge, the write is not performed, and all outputs return to reset values.
